// File: rtl/id_exe_pipe_reg.sv
// -----------------------------------------------------------------------------
// id_exe_pipe_reg
//
// ID->EXE pipeline register of the 5-stage ARM core. Every rising edge it
// captures the decoded control bits, register operands and shifter operand
// produced by ID and presents them to EXE (operand-2 generator, ALU, branch
// adder, forwarding unit).
//
// Stage movement (no valid/ready handshake; the hazard unit drives
// freeze/flush and this register obeys them):
//   rst == 0            : asynchronous clear of every output, immediate.
//   flush == 1          : a bubble is written (overrides freeze).
//   freeze == 1         : every output holds, bubble counter holds.
//   otherwise           : id_* is loaded; an invalid ID slot (id_valid == 0)
//                         is written as a bubble, exactly like a flush.
// A bubble clears the control bits AND zeroes the datapath fields, so the
// forwarding unit can never match a register index carried by a bubble.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   freeze, flush       hazard stall / branch-taken kill
//   id_*                decoded instruction fields from ID
//   exe_*               registered copies of the id_* fields
//   exe_bubbles         saturating count of bubbles written since reset
//
// All fields pass bit-exact; sign extension of shift_op / imm24 happens in EXE.
// Every output comes straight from a flop: no input-to-output comb path.
// -----------------------------------------------------------------------------
module id_exe_pipe_reg #(
  parameter int WORD  = 32,
  parameter int RADDR = 4,
  parameter int CMD_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [WORD-1:0]  id_pc,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             id_mem_w_en,
  input  logic             id_b,
  input  logic             id_s,
  input  logic [CMD_W-1:0] id_exe_cmd,
  input  logic [WORD-1:0]  id_val_rn,
  input  logic [WORD-1:0]  id_val_rm,
  input  logic             id_imm,
  input  logic [11:0]      id_shift_op,
  input  logic [23:0]      id_imm24,
  input  logic [RADDR-1:0] id_dest,
  input  logic [RADDR-1:0] id_src1,
  input  logic [RADDR-1:0] id_src2,
  input  logic [3:0]       id_sr,
  output logic             exe_valid,
  output logic [WORD-1:0]  exe_pc,
  output logic             exe_wb_en,
  output logic             exe_mem_r_en,
  output logic             exe_mem_w_en,
  output logic             exe_b,
  output logic             exe_s,
  output logic [CMD_W-1:0] exe_exe_cmd,
  output logic [WORD-1:0]  exe_val_rn,
  output logic [WORD-1:0]  exe_val_rm,
  output logic             exe_imm,
  output logic [11:0]      exe_shift_op,
  output logic [23:0]      exe_imm24,
  output logic [RADDR-1:0] exe_dest,
  output logic [RADDR-1:0] exe_src1,
  output logic [RADDR-1:0] exe_src2,
  output logic [3:0]       exe_sr,
  output logic [7:0]       exe_bubbles
);

  // One bundle for the whole stage so reset and bubble clear every field
  // with a single assignment and no field can be forgotten.
  typedef struct packed {
    logic             valid;
    logic [WORD-1:0]  pc;
    logic             wb_en;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             b;
    logic             s;
    logic [CMD_W-1:0] exe_cmd;
    logic [WORD-1:0]  val_rn;
    logic [WORD-1:0]  val_rm;
    logic             imm;
    logic [11:0]      shift_op;
    logic [23:0]      imm24;
    logic [RADDR-1:0] dest;
    logic [RADDR-1:0] src1;
    logic [RADDR-1:0] src2;
    logic [3:0]       sr;
  } stage_t;

  stage_t stage_d;
  stage_t stage_q;
  logic   advance;      // the register is written this edge
  logic   take_bubble;  // what gets written is a bubble
  logic [7:0] bubbles_q;

  always_comb begin
    stage_d          = '0;
    stage_d.valid    = id_valid;
    stage_d.pc       = id_pc;
    stage_d.wb_en    = id_wb_en;
    stage_d.mem_r_en = id_mem_r_en;
    stage_d.mem_w_en = id_mem_w_en;
    stage_d.b        = id_b;
    stage_d.s        = id_s;
    stage_d.exe_cmd  = id_exe_cmd;
    stage_d.val_rn   = id_val_rn;
    stage_d.val_rm   = id_val_rm;
    stage_d.imm      = id_imm;
    stage_d.shift_op = id_shift_op;
    stage_d.imm24    = id_imm24;
    stage_d.dest     = id_dest;
    stage_d.src1     = id_src1;
    stage_d.src2     = id_src2;
    stage_d.sr       = id_sr;
  end

  // Flush beats freeze; an invalid slot only becomes a bubble when the
  // register actually advances (a frozen invalid slot is just held).
  always_comb begin
    advance     = flush | ~freeze;
    take_bubble = flush | (~freeze & ~id_valid);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= '0;
    end else if (advance) begin
      if (take_bubble) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end
  end

  // Saturating bubble counter: sticks at 8'hFF so a long flush storm never
  // wraps back to a small number.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubbles_q <= 8'd0;
    end else if (advance && take_bubble && (bubbles_q != 8'hFF)) begin
      bubbles_q <= bubbles_q + 8'd1;
    end
  end

  assign exe_valid    = stage_q.valid;
  assign exe_pc       = stage_q.pc;
  assign exe_wb_en    = stage_q.wb_en;
  assign exe_mem_r_en = stage_q.mem_r_en;
  assign exe_mem_w_en = stage_q.mem_w_en;
  assign exe_b        = stage_q.b;
  assign exe_s        = stage_q.s;
  assign exe_exe_cmd  = stage_q.exe_cmd;
  assign exe_val_rn   = stage_q.val_rn;
  assign exe_val_rm   = stage_q.val_rm;
  assign exe_imm      = stage_q.imm;
  assign exe_shift_op = stage_q.shift_op;
  assign exe_imm24    = stage_q.imm24;
  assign exe_dest     = stage_q.dest;
  assign exe_src1     = stage_q.src1;
  assign exe_src2     = stage_q.src2;
  assign exe_sr       = stage_q.sr;
  assign exe_bubbles  = bubbles_q;

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_id_exe_pipe_reg
//
// Bench for the ID->EXE pipeline register. The reference model holds the
// expected stage contents as one flat vector plus an integer bubble count,
// updated from the stage rules (reset / flush / freeze / load, invalid load
// is a bubble). Expected vectors go through exp_q and are popped and compared
// after each edge inside the scenario tasks.
// -----------------------------------------------------------------------------
module tb_id_exe_pipe_reg;

  localparam int VW = 159;  // width of the flat stage vector

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT inputs
  logic        freeze = 1'b0;
  logic        flush  = 1'b0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic        id_wb_en, id_mem_r_en, id_mem_w_en, id_b, id_s;
  logic [3:0]  id_exe_cmd;
  logic [31:0] id_val_rn, id_val_rm;
  logic        id_imm;
  logic [11:0] id_shift_op;
  logic [23:0] id_imm24;
  logic [3:0]  id_dest, id_src1, id_src2, id_sr;

  // DUT outputs
  logic        exe_valid;
  logic [31:0] exe_pc;
  logic        exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s;
  logic [3:0]  exe_exe_cmd;
  logic [31:0] exe_val_rn, exe_val_rm;
  logic        exe_imm;
  logic [11:0] exe_shift_op;
  logic [23:0] exe_imm24;
  logic [3:0]  exe_dest, exe_src1, exe_src2, exe_sr;
  logic [7:0]  exe_bubbles;

  id_exe_pipe_reg dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en), .id_b(id_b),
    .id_s(id_s), .id_exe_cmd(id_exe_cmd), .id_val_rn(id_val_rn),
    .id_val_rm(id_val_rm), .id_imm(id_imm), .id_shift_op(id_shift_op),
    .id_imm24(id_imm24), .id_dest(id_dest), .id_src1(id_src1),
    .id_src2(id_src2), .id_sr(id_sr),
    .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_wb_en(exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .exe_mem_w_en(exe_mem_w_en), .exe_b(exe_b),
    .exe_s(exe_s), .exe_exe_cmd(exe_exe_cmd), .exe_val_rn(exe_val_rn),
    .exe_val_rm(exe_val_rm), .exe_imm(exe_imm), .exe_shift_op(exe_shift_op),
    .exe_imm24(exe_imm24), .exe_dest(exe_dest), .exe_src1(exe_src1),
    .exe_src2(exe_src2), .exe_sr(exe_sr), .exe_bubbles(exe_bubbles)
  );

  logic [VW-1:0] id_vec, dut_vec;
  assign id_vec = {id_valid, id_pc, id_wb_en, id_mem_r_en, id_mem_w_en, id_b,
                   id_s, id_exe_cmd, id_val_rn, id_val_rm, id_imm, id_shift_op,
                   id_imm24, id_dest, id_src1, id_src2, id_sr};
  assign dut_vec = {exe_valid, exe_pc, exe_wb_en, exe_mem_r_en, exe_mem_w_en,
                    exe_b, exe_s, exe_exe_cmd, exe_val_rn, exe_val_rm, exe_imm,
                    exe_shift_op, exe_imm24, exe_dest, exe_src1, exe_src2,
                    exe_sr};

  // scoreboard
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] m_state;
  int            m_bub;
  logic [VW-1:0] exp_v;
  int            checks = 0;
  int            passes = 0;

  // ---------------------------------------------------------------- drivers
  task automatic drive_random_id(input logic valid);
    id_valid    = valid;
    id_pc       = $urandom;
    id_wb_en    = 1'($urandom_range(0, 1));
    id_mem_r_en = 1'($urandom_range(0, 1));
    id_mem_w_en = 1'($urandom_range(0, 1));
    id_b        = 1'($urandom_range(0, 1));
    id_s        = 1'($urandom_range(0, 1));
    id_exe_cmd  = 4'($urandom_range(0, 15));
    id_val_rn   = $urandom;
    id_val_rm   = $urandom;
    id_imm      = 1'($urandom_range(0, 1));
    id_shift_op = 12'($urandom_range(0, 4095));
    id_imm24    = 24'($urandom);
    id_dest     = 4'($urandom_range(0, 15));
    id_src1     = 4'($urandom_range(0, 15));
    id_src2     = 4'($urandom_range(0, 15));
    id_sr       = 4'($urandom_range(0, 15));
  endtask

  task automatic drive_all_ones();
    id_valid = 1'b1; id_pc = '1; id_wb_en = 1'b1; id_mem_r_en = 1'b1;
    id_mem_w_en = 1'b1; id_b = 1'b1; id_s = 1'b1; id_exe_cmd = '1;
    id_val_rn = '1; id_val_rm = '1; id_imm = 1'b1; id_shift_op = '1;
    id_imm24 = '1; id_dest = '1; id_src1 = '1; id_src2 = '1; id_sr = '1;
  endtask

  // Applies flush/freeze for one edge, advances the model and queues the
  // expected stage contents. Inputs change #1 after the edge.
  task automatic step(input logic fl, input logic fr);
    flush  = fl;
    freeze = fr;
    #1;
    if (fl || (!fr && !id_valid)) begin
      m_state = '0;
      if (m_bub < 255) m_bub++;
    end else if (!fr) begin
      m_state = id_vec;
    end
    exp_q.push_back(m_state);
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    drive_all_ones();
    @(posedge clk); #1;  // loads all ones so the clear is visible
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (dut_vec !== '0) $display("FAIL reset_fields got=%h exp=0", dut_vec);
    else passes++;
    checks++;
    if (exe_bubbles !== 8'd0) $display("FAIL reset_bubbles got=%0d exp=0", exe_bubbles);
    else passes++;
    m_state = '0;
    m_bub   = 0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_load();
    drive_random_id(1'b1);
    id_val_rn   = 32'h1234_5678;
    id_shift_op = 12'h2A5;
    id_dest     = 4'd7;
    step(1'b0, 1'b0);
    exp_v = exp_q.pop_front();
    checks++;
    if (dut_vec !== exp_v) $display("FAIL load_vec got=%h exp=%h", dut_vec, exp_v);
    else passes++;
    checks++;
    if ({exe_valid, exe_val_rn, exe_shift_op, exe_dest} !== {1'b1, 32'h1234_5678, 12'h2A5, 4'd7})
      $display("FAIL load_fields got=%b/%h/%h/%0d exp=1/12345678/2a5/7",
               exe_valid, exe_val_rn, exe_shift_op, exe_dest);
    else passes++;
  endtask

  task automatic test_freeze();
    logic [VW-1:0] held;
    held = dut_vec;
    for (int i = 0; i < 3; i++) begin
      drive_random_id(1'($urandom_range(0, 1)));
      step(1'b0, 1'b1);
      exp_v = exp_q.pop_front();
      checks++;
      if (dut_vec !== exp_v) $display("FAIL freeze_hold%0d got=%h exp=%h", i, dut_vec, exp_v);
      else passes++;
      checks++;
      if (exe_bubbles !== 8'(m_bub)) $display("FAIL freeze_bub%0d got=%0d exp=%0d", i, exe_bubbles, m_bub);
      else passes++;
    end
    checks++;
    if (exp_v !== held) $display("FAIL freeze_model got=%h exp=%h", exp_v, held);
    else passes++;
    drive_random_id(1'b1);
    step(1'b0, 1'b0);
    exp_v = exp_q.pop_front();
    checks++;
    if (dut_vec !== exp_v) $display("FAIL freeze_release got=%h exp=%h", dut_vec, exp_v);
    else passes++;
  endtask

  task automatic test_flush_freeze();
    int bub_before;
    bub_before = m_bub;
    drive_random_id(1'b1);
    id_wb_en    = 1'b1;
    id_mem_w_en = 1'b1;
    id_dest     = 4'd9;
    step(1'b1, 1'b1);
    exp_v = exp_q.pop_front();
    checks++;
    if (dut_vec !== exp_v) $display("FAIL flush_vec got=%h exp=%h", dut_vec, exp_v);
    else passes++;
    checks++;
    if ({exe_valid, exe_wb_en, exe_mem_w_en, exe_dest} !== 7'd0)
      $display("FAIL flush_ctrl got=%b%b%b/%0d exp=000/0", exe_valid, exe_wb_en, exe_mem_w_en, exe_dest);
    else passes++;
    checks++;
    if (exe_bubbles !== 8'(bub_before + 1))
      $display("FAIL flush_bub got=%0d exp=%0d", exe_bubbles, bub_before + 1);
    else passes++;
  endtask

  task automatic test_random();
    logic fl, fr;
    for (int i = 0; i < 200; i++) begin
      drive_random_id(($urandom_range(0, 3) != 0));
      fl = ($urandom_range(0, 7) == 0);
      fr = ($urandom_range(0, 3) == 0);
      step(fl, fr);
      exp_v = exp_q.pop_front();
      checks++;
      if (dut_vec !== exp_v) $display("FAIL random%0d_vec got=%h exp=%h", i, dut_vec, exp_v);
      else passes++;
      checks++;
      if (exe_bubbles !== 8'(m_bub)) $display("FAIL random%0d_bub got=%0d exp=%0d", i, exe_bubbles, m_bub);
      else passes++;
      if (!exe_valid) begin
        checks++;
        if ({exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s} !== 5'd0)
          $display("FAIL random%0d_ctrl got=%b%b%b%b%b exp=00000", i,
                   exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_b, exe_s);
        else passes++;
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      drive_random_id(1'b1);
      step(1'b1, 1'($urandom_range(0, 1)));
      exp_v = exp_q.pop_front();
      checks++;
      if (exe_bubbles !== 8'(m_bub) || dut_vec !== exp_v)
        $display("FAIL sat%0d got=%0d/%h exp=%0d/%h", i, exe_bubbles, dut_vec, m_bub, exp_v);
      else passes++;
    end
    checks++;
    if (exe_bubbles !== 8'hFF) $display("FAIL sat_final got=%h exp=ff", exe_bubbles);
    else passes++;
  endtask

  task automatic test_async_reset();
    drive_random_id(1'b1);
    step(1'b0, 1'b0);
    exp_v = exp_q.pop_front();
    checks++;
    if (dut_vec !== exp_v) $display("FAIL areset_preload got=%h exp=%h", dut_vec, exp_v);
    else passes++;
    @(negedge clk);
    freeze = 1'b1;
    flush  = 1'b1;
    rst    = 1'b0;
    #1;
    checks++;
    if (dut_vec !== '0 || exe_bubbles !== 8'd0)
      $display("FAIL areset_clear got=%h/%0d exp=0/0", dut_vec, exe_bubbles);
    else passes++;
    m_state = '0;
    m_bub   = 0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    drive_random_id(1'b1);
    step(1'b0, 1'b0);
    exp_v = exp_q.pop_front();
    checks++;
    if (dut_vec !== exp_v || exe_valid !== 1'b1)
      $display("FAIL areset_reload got=%h exp=%h", dut_vec, exp_v);
    else passes++;
    checks++;
    if (exe_bubbles !== 8'd0) $display("FAIL areset_bub got=%0d exp=0", exe_bubbles);
    else passes++;
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    test_reset();
    test_load();
    test_freeze();
    test_flush_freeze();
    test_random();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
